aata_vec_packer: RTL and testbench
==================================

Name: aata_vec_packer

Overview:
- Upstream feeder for the 128-input approximate adder-tree stage.
- Collects a byte-wide input stream into 128-bit vectors and presents each vector, held stable, on a valid/ready output. The vector drives the tree's In[127:0] bus.
- Two registers: an assembly register and an output register. This allows full-rate streaming while the consumer stalls.
- Supports early flush with zero padding, for frames that are not a multiple of 16 beats.

Parameters:
- BEAT_W, 8: input beat width in bits.
- VEC_W, 128: output vector width. Must be an integer multiple of BEAT_W.
- NBEATS, VEC_W/BEAT_W (16): derived value, not overridable.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, BEAT_W: stream beat.
- in_valid, input, 1: in_data is valid.
- in_last, input, 1: final beat of the frame. Qualified by in_valid. Forces a flush.
- in_ready, output, 1: packer can accept a beat this cycle.
- vec_out, output, VEC_W: assembled vector, fed to the tree's In bus.
- vec_valid, output, 1: vec_out is valid.
- vec_ready, input, 1: consumer accepts vec_out.
- vec_partial, output, 1: current vec_out was flushed before NBEATS beats (zero padded).
- vec_count, output, 16: number of vectors accepted downstream. Wraps at 2^16.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - vec_out = 0, vec_valid = 0, vec_partial = 0, vec_count = 0.
  - Beat index = 0, assembly register = 0, asm_full = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards the partial assembly and any pending output. No vector is emitted.
- Input accept: occurs on a clk edge where in_valid && in_ready.
- in_ready = !asm_full. It is combinational from the registered flag only; it has no path from vec_ready.
- Packing order:
  - Beat k (k = 0..NBEATS-1) lands in assembly bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k].
  - The first beat of a vector therefore drives In[7:0]; beat 15 drives In[127:120].
- Completion: the accepted beat is beat NBEATS-1, or in_last = 1.
  - On completion, the beat index returns to 0.
  - On an in_last flush, unwritten lanes are 0 and the vector is tagged partial.
  - in_last on beat NBEATS-1 gives a full vector, partial = 0.
- Out slot free: defined as !vec_valid || vec_ready at that edge.
- Completion edge with the out slot free:
  - Completed vector (including the current beat) loads directly into vec_out.
  - vec_valid = 1 the next cycle.
  - Latency from the final beat to vec_valid is 1 cycle.
- Completion edge with the out slot busy:
  - Vector is held in the assembly register and asm_full is set.
  - in_ready = 0 until transfer.
- Transfer from a full assembly register:
  - Occurs at the first edge where asm_full && out slot free.
  - Assembly register moves to vec_out (with its partial tag).
  - asm_full clears, so in_ready = 1 the following cycle.
- Output handshake:
  - vec_out and vec_partial are stable while vec_valid && !vec_ready.
  - vec_valid drops after the accepting edge unless a new vector loads at that same edge (back-to-back case).
- vec_count increments by 1 on every edge with vec_valid && vec_ready. It wraps from 0xFFFF to 0.
- Throughput: with vec_ready held at 1, one beat is accepted per cycle indefinitely, and one vector is produced every NBEATS cycles.
- Assembly register lanes are cleared to 0 when a new vector begins (beat index 0 accepted). Stale data never leaks into a partial vector.
- in_last with in_valid = 0 is ignored.
- A simultaneous transfer and accept of beat 0 is impossible: in_ready = 0 while asm_full.

Test Plan:
- Reset then 16 beats 0x00..0x0F, vec_ready = 1:
  - vec_valid rises 1 cycle after beat 15.
  - vec_out = 0x0F0E0D0C0B0A09080706050403020100, vec_partial = 0, vec_count = 1 after accept.
- 3 beats 0xAA, 0xBB, 0xCC with in_last on the third:
  - vec_out = 0x…00CCBBAA (upper 104 bits 0), vec_partial = 1.
  - The next full vector has no residue from these beats.
- vec_ready = 0, stream 48 beats of 0xFF continuously:
  - First vector is held in vec_out; second fills the assembly register; in_ready = 0 from cycle 33.
  - Raising vec_ready drains both vectors (all-ones) on consecutive cycles.
  - in_ready returns 1 one cycle after the transfer.
- Continuous 160 beats, vec_ready = 1:
  - in_ready is never 0; 10 vectors are emitted exactly 16 cycles apart; vec_count = 10.
- rst asserted after beat 7 of a vector, then 16 beats of 0x55:
  - All outputs are 0 in the cycle after reset; no vector is emitted for the aborted data.
  - Next vec_out = all 0x55, vec_count = 1.
- Preload vec_count to 0xFFFF (2^16-1 vector accepts) then 1 more accept -> vec_count = 0x0000.

Source files
------------

// File: rtl/aata_vec_packer.sv
// aata_vec_packer: packs a byte stream into 128-bit vectors for the adder tree.
// Assembly register plus output register; early flush zero-pads short frames.
module aata_vec_packer #(
    parameter int BEAT_W = 8,
    parameter int VEC_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [VEC_W-1:0]  vec_out,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic              vec_partial,
    output logic [15:0]       vec_count
);

    localparam int NBEATS = VEC_W / BEAT_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    logic [IDX_W-1:0] beat_idx;
    logic [VEC_W-1:0] asm_reg;
    logic [VEC_W-1:0] asm_next;
    logic             asm_full;
    logic             asm_partial;

    logic accept;
    logic slot_free;
    logic out_take;
    logic last_lane;
    logic complete;
    logic short_flush;
    logic drain;

    // in_ready depends only on the registered full flag, never on vec_ready
    assign in_ready    = !asm_full;
    assign accept      = in_valid && in_ready;
    assign slot_free   = !vec_valid || vec_ready;
    assign out_take    = vec_valid && vec_ready;
    assign last_lane   = (beat_idx == LAST_IDX);
    assign complete    = accept && (last_lane || in_last);
    assign short_flush = in_last && !last_lane;
    assign drain       = asm_full && slot_free;

    // Merge the incoming beat into its lane; lane 0 starts from a clean vector
    always_comb begin
        asm_next = (beat_idx == '0) ? '0 : asm_reg;
        for (int k = 0; k < NBEATS; k++) begin
            if (beat_idx == IDX_W'(k)) begin
                asm_next[k*BEAT_W +: BEAT_W] = in_data;
            end
        end
    end

    // Assembly register, beat index and the held-vector flag
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx    <= '0;
            asm_reg     <= '0;
            asm_full    <= 1'b0;
            asm_partial <= 1'b0;
        end else begin
            if (accept) begin
                asm_reg  <= asm_next;
                beat_idx <= complete ? '0 : beat_idx + 1'b1;
            end
            if (complete) begin
                asm_partial <= short_flush;
            end
            if (complete && !slot_free) begin
                asm_full <= 1'b1;
            end else if (drain) begin
                asm_full <= 1'b0;
            end
        end
    end

    // Output register: held vector first, else a vector completing this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out     <= '0;
            vec_valid   <= 1'b0;
            vec_partial <= 1'b0;
        end else if (drain) begin
            vec_out     <= asm_reg;
            vec_partial <= asm_partial;
            vec_valid   <= 1'b1;
        end else if (complete && slot_free) begin
            vec_out     <= asm_next;
            vec_partial <= short_flush;
            vec_valid   <= 1'b1;
        end else if (vec_ready) begin
            vec_valid   <= 1'b0;
        end
    end

    // Count of vectors taken downstream, wrapping at 2^16
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_count <= '0;
        end else if (out_take) begin
            vec_count <= vec_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_aata_vec_packer.sv
// tb_aata_vec_packer: scenario tasks driving aata_vec_packer,
// checked against a byte-queue reference model of the packing rules.
module tb_aata_vec_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] vec_out;
    logic         vec_valid;
    logic         vec_ready;
    logic         vec_partial;
    logic [15:0]  vec_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] v;
        logic         p;
    } exp_t;

    typedef struct {
        logic         acc;
        logic         hs;
        logic         vv;
        logic         op;
        logic         ir;
        logic [127:0] ov;
    } smp_t;

    exp_t       expq[$];
    logic [7:0] cur[$];

    always #5 clk = ~clk;

    aata_vec_packer #(.BEAT_W(8), .VEC_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .vec_out    (vec_out),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_partial(vec_partial),
        .vec_count  (vec_count)
    );

    // Reference: collect bytes; 16 bytes or a last flag make one vector
    function automatic void model_accept(input logic [7:0] d, input logic l);
        exp_t e;
        cur.push_back(d);
        if (cur.size() == 16 || l) begin
            e.v = '0;
            foreach (cur[i]) e.v[i*8 +: 8] = cur[i];
            e.p = (cur.size() < 16);
            expq.push_back(e);
            cur.delete();
        end
    endfunction

    function automatic void model_clear();
        cur.delete();
        expq.delete();
    endfunction

    // Apply inputs at a falling edge, sample pre-edge state, advance one cycle
    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic r, output smp_t s);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        vec_ready = r;
        s.acc = v && in_ready;
        s.hs  = vec_valid && r;
        s.vv  = vec_valid;
        s.ov  = vec_out;
        s.op  = vec_partial;
        s.ir  = in_ready;
        if (s.acc) model_accept(d, l);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        vec_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        in_last = 1'b0;
        vec_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_clear();
        checks += 5;
        if (vec_out !== '0) begin
            errors++; $display("FAIL reset_vec_out: got %h expected 0", vec_out);
        end
        if (vec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_vec_valid: got %b expected 0", vec_valid);
        end
        if (vec_partial !== 1'b0) begin
            errors++; $display("FAIL reset_vec_partial: got %b expected 0", vec_partial);
        end
        if (vec_count !== 16'h0) begin
            errors++; $display("FAIL reset_vec_count: got %h expected 0", vec_count);
        end
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_full_vector();
        smp_t s;
        exp_t e;
        logic early;
        do_reset();
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1, s);
            if (s.vv) early = 1'b1;
        end
        checks += 4;
        if (early !== 1'b0) begin
            errors++; $display("FAIL full_early_valid: got 1 expected 0");
        end
        if (vec_valid !== 1'b1) begin
            errors++; $display("FAIL full_latency: vec_valid got %b expected 1", vec_valid);
        end
        if (vec_out !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            errors++; $display("FAIL full_vec_out: got %h expected 0f0e..0100", vec_out);
        end
        if (vec_partial !== 1'b0) begin
            errors++; $display("FAIL full_partial: got %b expected 0", vec_partial);
        end
        drive(1'b0, 8'h0, 1'b0, 1'b1, s);
        if (s.hs) begin
            checks++;
            e = expq.pop_front();
            if (s.ov !== e.v || s.op !== e.p) begin
                errors++; $display("FAIL full_model: got %h/%b expected %h/%b", s.ov, s.op, e.v, e.p);
            end
        end
        checks += 2;
        if (vec_count !== 16'd1) begin
            errors++; $display("FAIL full_count: got %0d expected 1", vec_count);
        end
        if (vec_valid !== 1'b0) begin
            errors++; $display("FAIL full_valid_drop: got %b expected 0", vec_valid);
        end
    endtask

    task automatic test_partial();
        smp_t s;
        exp_t e;
        int nhs;
        drive(1'b1, 8'hAA, 1'b0, 1'b1, s);
        drive(1'b1, 8'hBB, 1'b0, 1'b1, s);
        drive(1'b1, 8'hCC, 1'b1, 1'b1, s);
        checks += 3;
        if (vec_valid !== 1'b1) begin
            errors++; $display("FAIL partial_valid: got %b expected 1", vec_valid);
        end
        if (vec_out !== 128'h00CCBBAA) begin
            errors++; $display("FAIL partial_vec_out: got %h expected 00ccbbaa", vec_out);
        end
        if (vec_partial !== 1'b1) begin
            errors++; $display("FAIL partial_tag: got %b expected 1", vec_partial);
        end
        nhs = 0;
        for (int c = 0; c < 22; c++) begin
            drive(c < 16, 8'($urandom), 1'b0, 1'b1, s);
            if (s.hs) begin
                nhs++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL partial_sb: unexpected vector %h", s.ov);
                end else begin
                    e = expq.pop_front();
                    if (s.ov !== e.v || s.op !== e.p) begin
                        errors++; $display("FAIL partial_sb: got %h/%b expected %h/%b", s.ov, s.op, e.v, e.p);
                    end
                end
            end
        end
        checks++;
        if (nhs != 2) begin
            errors++; $display("FAIL partial_nvec: got %0d expected 2", nhs);
        end
    endtask

    task automatic test_backpressure();
        smp_t s;
        exp_t e;
        int acc_n, nhs, low_cyc;
        int hs_cyc[3];
        logic ir41;
        do_reset();
        acc_n = 0; nhs = 0; low_cyc = 0; ir41 = 1'b0;
        hs_cyc = '{0, 0, 0};
        for (int c = 1; c <= 90; c++) begin
            drive(acc_n < 48, 8'hFF, 1'b0, c >= 40, s);
            if (s.acc) acc_n++;
            if (!s.ir && low_cyc == 0) low_cyc = c;
            if (c == 41) ir41 = s.ir;
            if (s.hs) begin
                if (nhs < 3) hs_cyc[nhs] = c;
                nhs++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL bp_sb: unexpected vector %h", s.ov);
                end else begin
                    e = expq.pop_front();
                    if (s.ov !== e.v || s.op !== e.p || s.ov !== {128{1'b1}}) begin
                        errors++; $display("FAIL bp_sb: got %h/%b expected %h/%b", s.ov, s.op, e.v, e.p);
                    end
                end
            end
        end
        checks += 6;
        if (low_cyc != 33) begin
            errors++; $display("FAIL bp_ready_low: first low cycle %0d expected 33", low_cyc);
        end
        if (nhs != 3) begin
            errors++; $display("FAIL bp_nvec: got %0d expected 3", nhs);
        end
        if (hs_cyc[0] != 40) begin
            errors++; $display("FAIL bp_first_drain: cycle %0d expected 40", hs_cyc[0]);
        end
        if (hs_cyc[1] != 41) begin
            errors++; $display("FAIL bp_second_drain: cycle %0d expected 41", hs_cyc[1]);
        end
        if (ir41 !== 1'b1) begin
            errors++; $display("FAIL bp_ready_return: got %b expected 1", ir41);
        end
        if (acc_n != 48) begin
            errors++; $display("FAIL bp_accepts: got %0d expected 48", acc_n);
        end
    endtask

    task automatic test_stream();
        smp_t s;
        exp_t e;
        int nhs, prev, ready_low, gap_err;
        do_reset();
        nhs = 0; prev = 0; ready_low = 0; gap_err = 0;
        for (int c = 0; c < 190; c++) begin
            drive(c < 160, 8'($urandom), 1'b0, 1'b1, s);
            if (c < 160 && !s.ir) ready_low++;
            if (s.hs) begin
                if (nhs > 0 && c - prev != 16) gap_err++;
                prev = c;
                nhs++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stream_sb: unexpected vector %h", s.ov);
                end else begin
                    e = expq.pop_front();
                    if (s.ov !== e.v || s.op !== e.p) begin
                        errors++; $display("FAIL stream_sb: got %h/%b expected %h/%b", s.ov, s.op, e.v, e.p);
                    end
                end
            end
        end
        checks += 4;
        if (ready_low != 0) begin
            errors++; $display("FAIL stream_ready: low %0d cycles expected 0", ready_low);
        end
        if (gap_err != 0) begin
            errors++; $display("FAIL stream_spacing: %0d bad gaps expected 0", gap_err);
        end
        if (nhs != 10) begin
            errors++; $display("FAIL stream_nvec: got %0d expected 10", nhs);
        end
        if (vec_count !== 16'd10) begin
            errors++; $display("FAIL stream_count: got %0d expected 10", vec_count);
        end
    endtask

    task automatic test_reset_mid();
        smp_t s;
        exp_t e;
        int nhs;
        do_reset();
        for (int c = 0; c < 24; c++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, s);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        vec_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks += 5;
        if (vec_out !== '0) begin
            errors++; $display("FAIL mid_vec_out: got %h expected 0", vec_out);
        end
        if (vec_valid !== 1'b0) begin
            errors++; $display("FAIL mid_vec_valid: got %b expected 0", vec_valid);
        end
        if (vec_partial !== 1'b0) begin
            errors++; $display("FAIL mid_partial: got %b expected 0", vec_partial);
        end
        if (vec_count !== 16'd0) begin
            errors++; $display("FAIL mid_count: got %0d expected 0", vec_count);
        end
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready);
        end
        nhs = 0;
        for (int c = 0; c < 30; c++) begin
            drive(c < 16, 8'h55, 1'b0, 1'b1, s);
            if (s.hs) begin
                nhs++;
                checks++;
                e = (expq.size() != 0) ? expq.pop_front() : '{v: '0, p: 1'b1};
                if (s.ov !== {16{8'h55}} || s.op !== 1'b0 || s.ov !== e.v) begin
                    errors++; $display("FAIL mid_vector: got %h/%b expected all 55/0", s.ov, s.op);
                end
            end
        end
        checks += 2;
        if (nhs != 1) begin
            errors++; $display("FAIL mid_nvec: got %0d expected 1", nhs);
        end
        if (vec_count !== 16'd1) begin
            errors++; $display("FAIL mid_final_count: got %0d expected 1", vec_count);
        end
    endtask

    task automatic test_random();
        smp_t s, ps;
        exp_t e;
        logic pr;
        logic r;
        int nhs;
        do_reset();
        nhs = 0;
        pr = 1'b1;
        ps = '{acc: 0, hs: 0, vv: 0, op: 0, ir: 0, ov: '0};
        for (int c = 0; c < 3040; c++) begin
            r = (c >= 3000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            drive((c < 3000) && ($urandom_range(0, 3) != 0), 8'($urandom),
                  $urandom_range(0, 7) == 0, r, s);
            if (ps.vv && !pr) begin
                checks++;
                if (!s.vv || s.ov !== ps.ov || s.op !== ps.op) begin
                    errors++; $display("FAIL rand_hold: got %b/%h expected 1/%h", s.vv, s.ov, ps.ov);
                end
            end
            if (s.hs) begin
                nhs++;
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_sb: unexpected vector %h", s.ov);
                end else begin
                    e = expq.pop_front();
                    if (s.ov !== e.v || s.op !== e.p) begin
                        errors++; $display("FAIL rand_sb: got %h/%b expected %h/%b", s.ov, s.op, e.v, e.p);
                    end
                end
            end
            ps = s;
            pr = r;
        end
        checks += 2;
        if (expq.size() != 0) begin
            errors++; $display("FAIL rand_drain: %0d vectors left expected 0", expq.size());
        end
        if (vec_count !== 16'(nhs)) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", vec_count, nhs);
        end
    endtask

    task automatic test_wrap();
        smp_t s;
        int nhs;
        do_reset();
        nhs = 0;
        for (int c = 0; c < 70000 && nhs < 65536; c++) begin
            drive(1'b1, 8'(c), 1'b1, 1'b1, s);
            if (expq.size() > 4) void'(expq.pop_front());
            if (s.hs) begin
                nhs++;
                if (nhs == 65535) begin
                    checks++;
                    if (vec_count !== 16'hFFFF) begin
                        errors++; $display("FAIL wrap_max: got %h expected ffff", vec_count);
                    end
                end
            end
        end
        checks += 2;
        if (nhs != 65536) begin
            errors++; $display("FAIL wrap_accepts: got %0d expected 65536", nhs);
        end
        if (vec_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h expected 0000", vec_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        vec_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_vector();
        test_partial();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
